// File: rtl/cache_fill_fsm_if.sv
// Handshake bundle between the cache fill engine, the cache arrays and the
// shared main-memory read port.
interface cache_fill_fsm_if #(
  parameter int DWIDTH      = 16,
  parameter int AWIDTH      = 16,
  parameter int BLOCK_WORDS = 8
);
  localparam int IW = $clog2(BLOCK_WORDS);

  logic              miss_detected;
  logic [AWIDTH-1:0] miss_addr;
  logic [DWIDTH-1:0] mem_data_in;
  logic              mem_data_valid;
  logic              fsm_busy;
  logic              mem_en;
  logic [AWIDTH-1:0] mem_addr;
  logic              write_data_array;
  logic [IW-1:0]     fill_word_idx;
  logic [DWIDTH-1:0] fill_data;
  logic              write_tag_array;
  logic              fill_done;

  // Fill engine side.
  modport master (
    input  miss_detected, miss_addr, mem_data_in, mem_data_valid,
    output fsm_busy, mem_en, mem_addr, write_data_array, fill_word_idx,
           fill_data, write_tag_array, fill_done
  );

  // Cache/memory side.
  modport slave (
    output miss_detected, miss_addr, mem_data_in, mem_data_valid,
    input  fsm_busy, mem_en, mem_addr, write_data_array, fill_word_idx,
           fill_data, write_tag_array, fill_done
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: issues one word request per cycle for a whole block,
// streams in-order returns into the data array and pulses the tag write on the last.
module cache_fill_fsm #(
  parameter int DWIDTH      = 16,
  parameter int AWIDTH      = 16,
  parameter int BLOCK_WORDS = 8,
  localparam int IW         = $clog2(BLOCK_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Counters are one bit wider than the word index so they can reach BLOCK_WORDS.
  localparam logic [IW:0]       BLOCK_CNT   = (IW+1)'(BLOCK_WORDS);
  localparam logic [IW:0]       LAST_CNT    = (IW+1)'(BLOCK_WORDS - 1);
  localparam logic [IW:0]       CNT_ONE     = (IW+1)'(1);
  localparam logic [AWIDTH-1:0] OFFSET_MASK = AWIDTH'((1 << (IW + 1)) - 1);

  state_t            state_q, state_d;
  logic [IW:0]       iss_q, iss_d;
  logic [IW:0]       rcv_q, rcv_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic              fill_done_q;

  logic issue;
  logic accept;
  logic last_beat;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      iss_q       <= '0;
      rcv_q       <= '0;
      base_q      <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iss_q       <= iss_d;
      rcv_q       <= rcv_d;
      base_q      <= base_d;
      fill_done_q <= last_beat;
    end
  end

  // Issue and receive qualifiers; a return with nothing outstanding is dropped.
  always_comb begin
    issue     = (state_q == FILL) && (iss_q < BLOCK_CNT);
    accept    = (state_q == FILL) && bus.mem_data_valid && (rcv_q < iss_q);
    last_beat = accept && (rcv_q == LAST_CNT);
  end

  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    state_d = state_q;
    iss_d   = iss_q;
    rcv_d   = rcv_q;
    base_d  = base_q;

    unique case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          state_d = FILL;
          iss_d   = '0;
          rcv_d   = '0;
          base_d  = bus.miss_addr & ~OFFSET_MASK;
        end
      end
      FILL: begin
        if (issue)     iss_d   = iss_q + CNT_ONE;
        if (accept)    rcv_d   = rcv_q + CNT_ONE;
        if (last_beat) state_d = IDLE;
      end
    endcase
  end

  // Stall is combinational so the pipeline freezes in the miss cycle itself.
  always_comb begin
    bus.fsm_busy         = (state_q == FILL) || bus.miss_detected;
    bus.mem_en           = issue;
    bus.mem_addr         = issue ? (base_q + AWIDTH'({iss_q, 1'b0})) : '0;
    bus.write_data_array = accept;
    bus.fill_word_idx    = rcv_q[IW-1:0];
    bus.fill_data        = bus.mem_data_in;
    bus.write_tag_array  = last_beat;
    bus.fill_done        = fill_done_q;
  end

endmodule
